sdram_read_arbiter: RTL and testbench
=====================================

// Module: sdram_read_arbiter
// PURPOSE
//  Two-port arbiter for the single SDRAM controller read port (22b word addr, 128b data).
//  Port V is the video line-buffer fetcher, which is deadline-critical. Port S is a
//  secondary bulk reader (sprite/asset loader).
//  V has fixed priority; an aging counter bounds S starvation.
//  Sits between the requesters and the SDRAM controller read channel, ahead of the
//  line buffer path.
// PARAMETERS
//  ADDR_W        22   SDRAM word address width
//  DATA_W        128  read data width (one 16-pixel palette word)
//  STARVE_LIMIT  8    V grants issued while S is waiting before S is forced ahead of V
// PORTS
//  clock        in   1       system clock; all state on posedge
//  reset        in   1       asynchronous, active-high reset
//  mem_wait     in   1       SDRAM controller not ready (init/refresh); blocks new grants
//  mem_ac       in   1       controller read acknowledge; 1-cycle pulse, data valid same cycle
//  mem_data     in   DATA_W  controller read data
//  mem_rd       out  1       read request to controller
//  mem_addr     out  ADDR_W  read address to controller
//  v_rd         in   1       video read request; held until v_ac
//  v_addr       in   ADDR_W  video read address; stable while v_rd=1
//  v_ac         out  1       video acknowledge; v_data valid this cycle
//  v_data       out  DATA_W  video read data
//  s_rd/s_addr  in   1/ADDR_W  secondary request/address; same rules as V
//  s_ac/s_data  out  1/DATA_W  secondary acknowledge/data
//  s_starved    out  1       1 while starve_cnt >= STARVE_LIMIT
// BEHAVIOUR
//  Reset values (async, immediate):
//   state=IDLE, starve_cnt=0
//   mem_rd=0, mem_addr=0, v_ac=0, s_ac=0, s_starved=0
//  FSM states: IDLE, GNT_V, GNT_S. State is registered.
//   mem_rd, mem_addr and the *_ac outputs are combinational muxes from state.
//  IDLE:
//   mem_rd=0 and mem_addr=0.
//   If mem_wait=1, stay in IDLE.
//   Else, if s_rd=1 and starve_cnt >= STARVE_LIMIT -> GNT_S.
//   Else if v_rd=1 -> GNT_V.
//   Else if s_rd=1 -> GNT_S.
//   Else stay in IDLE.
//  GNT_x (x = V or S):
//   mem_rd=x_rd and mem_addr=x_addr.
//   x_ac=mem_ac and x_data=mem_data. The other port's ac is 0.
//   mem_ac=1 -> IDLE (one dead cycle; requesters drop rd the cycle after ac).
//   x_rd=0 with mem_ac=0 (abort) -> IDLE. No ack is generated.
//   mem_wait is ignored once a grant is held.
//  Latency: a request seen in IDLE drives mem_rd in the next cycle.
//   After ac at cycle m, the earliest next grant drives mem_rd at cycle m+2.
//  starve_cnt (width clog2(STARVE_LIMIT+1)):
//   +1 on each IDLE->GNT_V transition while s_rd=1; saturates at STARVE_LIMIT.
//   Cleared on IDLE->GNT_S.
//   Holds if s_rd=0 (no decay).
//  v_data and s_data are both driven from mem_data at all times. Consumers qualify
//   them only with their own *_ac.
//  Simultaneous v_rd and s_rd in IDLE: V wins unless s_starved=1.
//  A new request arriving during the other port's grant waits for IDLE. It is never
//   pre-empted.
//  mem_ac while in IDLE (spurious): ignored. No ack is forwarded and state is unchanged.
//  Reset mid-grant: the grant is dropped immediately. The controller must tolerate
//   rd deasserting mid-transaction; the requester restarts from its own reset.
// STRUCTURE
//  Shared package sdram_pkg:
//   typedef enum logic [1:0] {ARB_IDLE, ARB_GNT_V, ARB_GNT_S} arb_state_t
//   localparams SDRAM_ADDR_W=22 and SDRAM_DATA_W=128
//  Single module. The starvation counter may be split out as sat_counter if reused
//   elsewhere; no other sub-modules.
// TESTING
//  1 Only v_rd=1, v_addr=22'h100028; mem_ac pulses 3 cycles after mem_rd rises
//    -> mem_addr=22'h100028, v_ac is a 1-cycle pulse, v_data=mem_data, s_ac stays 0.
//  2 v_rd and s_rd rise in the same cycle, STARVE_LIMIT=8, starve_cnt=0
//    -> GNT_V first, starve_cnt=1, then GNT_S on the next IDLE if v_rd=0.
//  3 v_rd re-requests continuously and s_rd is held high
//    -> exactly 8 V grants, then an S grant, then starve_cnt=0; s_starved high only
//       between the 8th V ack and the S grant.
//  4 mem_wait=1 with v_rd=1 -> mem_rd stays 0.
//    mem_wait falls -> mem_rd=1 one cycle later.
//    mem_wait rises during GNT_V -> grant held until mem_ac.
//  5 Abort: s_rd drops in GNT_S before mem_ac -> IDLE next cycle, no s_ac pulse.
//    A late mem_ac in IDLE -> no ack on either port.
//  6 reset asserted mid GNT_V (asynchronously, between clock edges)
//    -> mem_rd=0 and state=IDLE without waiting for a clock edge; all outputs at
//       reset values.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM read-port arbitration logic.
// Widths follow the SDRAM controller read channel (word address, palette-word data).
package sdram_pkg;

    localparam int SDRAM_ADDR_W = 22;
    localparam int SDRAM_DATA_W = 128;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GNT_V = 2'd1,
        ARB_GNT_S = 2'd2
    } arb_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous reset.
// Clear wins over increment; the count never exceeds MAX.
module sat_counter #(
    parameter int MAX = 8,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] count_o,
    output logic         at_max_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q < W'(MAX))) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o  = count_q;
    assign at_max_o = (count_q >= W'(MAX));

endmodule

// File: rtl/sdram_read_arbiter.sv
// Two-port arbiter for the SDRAM controller read port: video (V) has fixed priority,
// the secondary port (S) is forced ahead once V has won STARVE_LIMIT times while S waited.
module sdram_read_arbiter
    import sdram_pkg::*;
#(
    parameter int ADDR_W       = SDRAM_ADDR_W,
    parameter int DATA_W       = SDRAM_DATA_W,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_wait_i,
    input  logic              mem_ac_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              mem_rd_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              v_rd_i,
    input  logic [ADDR_W-1:0] v_addr_i,
    output logic              v_ac_o,
    output logic [DATA_W-1:0] v_data_o,
    input  logic              s_rd_i,
    input  logic [ADDR_W-1:0] s_addr_i,
    output logic              s_ac_o,
    output logic [DATA_W-1:0] s_data_o,
    output logic              s_starved_o
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    arb_state_t       state_q;
    arb_state_t       state_d;
    logic             grant_v;
    logic             grant_s;
    logic             starved;
    logic [CNT_W-1:0] starve_cnt;

    // New grants are only issued from IDLE; an active grant ignores mem_wait and
    // runs until the controller acks or the owner withdraws its request.
    always_comb begin
        state_d = state_q;
        grant_v = 1'b0;
        grant_s = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (!mem_wait_i) begin
                    if (s_rd_i && starved) begin
                        grant_s = 1'b1;
                    end else if (v_rd_i) begin
                        grant_v = 1'b1;
                    end else if (s_rd_i) begin
                        grant_s = 1'b1;
                    end
                end
                if (grant_v) begin
                    state_d = ARB_GNT_V;
                end else if (grant_s) begin
                    state_d = ARB_GNT_S;
                end
            end
            ARB_GNT_V: begin
                if (mem_ac_i || !v_rd_i) begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_GNT_S: begin
                if (mem_ac_i || !s_rd_i) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counts V wins that happened while S was waiting; any S grant resets the debt.
    sat_counter #(
        .MAX (STARVE_LIMIT),
        .W   (CNT_W)
    ) u_starve_cnt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .inc_i    (grant_v && s_rd_i),
        .clr_i    (grant_s),
        .count_o  (starve_cnt),
        .at_max_o (starved)
    );

    // Outputs are steered straight from the grant state so a reset drops them at once.
    always_comb begin
        mem_rd_o   = 1'b0;
        mem_addr_o = '0;
        v_ac_o     = 1'b0;
        s_ac_o     = 1'b0;
        case (state_q)
            ARB_GNT_V: begin
                mem_rd_o   = v_rd_i;
                mem_addr_o = v_addr_i;
                v_ac_o     = mem_ac_i;
            end
            ARB_GNT_S: begin
                mem_rd_o   = s_rd_i;
                mem_addr_o = s_addr_i;
                s_ac_o     = mem_ac_i;
            end
            default: begin
                mem_rd_o   = 1'b0;
                mem_addr_o = '0;
            end
        endcase
    end

    assign v_data_o    = mem_data_i;
    assign s_data_o    = mem_data_i;
    assign s_starved_o = starved;

endmodule

// File: tb/tb_sdram_read_arbiter.sv
// Self-checking bench for sdram_read_arbiter: directed vector table, hand-written
// starvation and async-reset sequences, then randomized traffic against a reference model.
module tb_sdram_read_arbiter;

    localparam int AW  = 22;
    localparam int DW  = 128;
    localparam int LIM = 8;

    localparam logic [AW-1:0] V_A = 22'h100028;
    localparam logic [AW-1:0] S_A = 22'h0A5A5A;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          mem_wait;
    logic          mem_ac;
    logic [DW-1:0] mem_data;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic          v_rd;
    logic [AW-1:0] v_addr;
    logic          v_ac;
    logic [DW-1:0] v_data;
    logic          s_rd;
    logic [AW-1:0] s_addr;
    logic          s_ac;
    logic [DW-1:0] s_data;
    logic          s_starved;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: who holds the port (0 nobody, 1 video, 2 secondary) and
    // how many video wins the secondary port has sat through.
    int holder    = 0;
    int s_debt    = 0;

    always #5 clk = ~clk;

    sdram_read_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .STARVE_LIMIT (LIM)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .mem_wait_i  (mem_wait),
        .mem_ac_i    (mem_ac),
        .mem_data_i  (mem_data),
        .mem_rd_o    (mem_rd),
        .mem_addr_o  (mem_addr),
        .v_rd_i      (v_rd),
        .v_addr_i    (v_addr),
        .v_ac_o      (v_ac),
        .v_data_o    (v_data),
        .s_rd_i      (s_rd),
        .s_addr_i    (s_addr),
        .s_ac_o      (s_ac),
        .s_data_o    (s_data),
        .s_starved_o (s_starved)
    );

    typedef struct {
        logic       v;
        logic       s;
        logic       w;
        logic       ac;
        logic       e_rd;
        logic [1:0] e_sel;
        logic       e_vac;
        logic       e_sac;
        logic       e_st;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic v, s, w, ac, e_rd, input logic [1:0] e_sel,
                                input logic e_vac, e_sac, e_st);
        vec_t r;
        r.v = v; r.s = s; r.w = w; r.ac = ac;
        r.e_rd = e_rd; r.e_sel = e_sel; r.e_vac = e_vac; r.e_sac = e_sac; r.e_st = e_st;
        return r;
    endfunction

    task automatic drive(input logic v, s, w, ac, input logic [AW-1:0] va, sa);
        v_rd     = v;
        s_rd     = s;
        mem_wait = w;
        mem_ac   = ac;
        v_addr   = va;
        s_addr   = sa;
        mem_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    function automatic void model_expect(output logic e_rd, output logic [AW-1:0] e_addr,
                                         output logic e_vac, e_sac, e_st);
        e_rd = 1'b0; e_addr = '0; e_vac = 1'b0; e_sac = 1'b0;
        if (holder == 1) begin
            e_rd = v_rd; e_addr = v_addr; e_vac = mem_ac;
        end else if (holder == 2) begin
            e_rd = s_rd; e_addr = s_addr; e_sac = mem_ac;
        end
        e_st = (s_debt >= LIM);
    endfunction

    // Advance the model by one clock using the inputs that were present before the edge.
    function automatic void model_step();
        if (holder == 0) begin
            if (!mem_wait) begin
                if (s_rd && s_debt >= LIM) begin
                    holder = 2; s_debt = 0;
                end else if (v_rd) begin
                    holder = 1;
                    if (s_rd) s_debt = (s_debt + 1 > LIM) ? LIM : s_debt + 1;
                end else if (s_rd) begin
                    holder = 2; s_debt = 0;
                end
            end
        end else begin
            if (mem_ac || !((holder == 1) ? v_rd : s_rd)) holder = 0;
        end
    endfunction

    task automatic check(input string name, input logic e_rd, input logic [AW-1:0] e_addr,
                         input logic e_vac, e_sac, e_st);
        vectors++;
        if (mem_rd !== e_rd || mem_addr !== e_addr || v_ac !== e_vac || s_ac !== e_sac ||
            s_starved !== e_st || v_data !== mem_data || s_data !== mem_data) begin
            miscompares++;
            $display("FAIL %s t=%0t: got rd=%b addr=%h vac=%b sac=%b starved=%b vdata_ok=%b sdata_ok=%b; want rd=%b addr=%h vac=%b sac=%b starved=%b data passthrough",
                     name, $time, mem_rd, mem_addr, v_ac, s_ac, s_starved,
                     v_data === mem_data, s_data === mem_data, e_rd, e_addr, e_vac, e_sac, e_st);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic model_cycle(input string name, output logic o_vac, o_sac, o_st);
        logic          e_rd, e_vac, e_sac, e_st;
        logic [AW-1:0] e_addr;
        @(negedge clk);
        model_expect(e_rd, e_addr, e_vac, e_sac, e_st);
        check(name, e_rd, e_addr, e_vac, e_sac, e_st);
        o_vac = v_ac;
        o_sac = s_ac;
        o_st  = s_starved;
        tick();
    endtask

    initial begin
        logic          e_rd, e_vac, e_sac, e_st;
        logic [AW-1:0] e_addr;
        logic          o_vac, o_sac, o_st;
        logic [AW-1:0] ra, rb;
        int            v_acks, s_acks, st_cycles;

        drive(0, 0, 0, 0, '0, '0);
        #2 rst = 1'b1;
        #1 check("reset_state", 1'b0, '0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        holder = 0; s_debt = 0;

        //        v  s  w  ac  rd sel vac sac st
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));  // lone V request in IDLE
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0));  // mem_rd rises
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 1, 1, 1, 0, 0));  // ack 3 cycles after mem_rd
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));  // dead cycle
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0));  // both request, V wins
        tbl.push_back(mk(1, 1, 0, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 1, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));  // S waits for IDLE
        tbl.push_back(mk(0, 1, 0, 1, 1, 2, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0));  // mem_wait blocks grant
        tbl.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));  // wait falls
        tbl.push_back(mk(1, 0, 1, 0, 1, 1, 0, 0, 0));  // wait ignored while granted
        tbl.push_back(mk(1, 0, 1, 1, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 2, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 2, 0, 0, 0));  // abort: S drops before ack
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0));  // late ack in IDLE ignored
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].s, tbl[i].w, tbl[i].ac, V_A, S_A);
            @(negedge clk);
            e_addr = (tbl[i].e_sel == 2'd1) ? V_A : (tbl[i].e_sel == 2'd2) ? S_A : '0;
            check($sformatf("table[%0d]", i), tbl[i].e_rd, e_addr, tbl[i].e_vac,
                  tbl[i].e_sac, tbl[i].e_st);
            tick();
        end
        $display("table: %0d directed cycles applied", tbl.size());

        // Starvation: V re-requests forever while S is held high.
        v_acks = 0; s_acks = 0; st_cycles = 0;
        for (int k = 0; k < LIM + 1; k++) begin
            drive(1, 1, 0, 0, V_A, S_A);
            model_cycle("starve_idle", o_vac, o_sac, o_st);
            st_cycles += int'(o_st);
            drive(1, 1, 0, 1, V_A, S_A);
            model_cycle("starve_gnt", o_vac, o_sac, o_st);
            st_cycles += int'(o_st);
            if (o_sac) s_acks++;
            else if (o_vac && s_acks == 0) v_acks++;
        end
        drive(0, 0, 0, 0, V_A, S_A);
        model_cycle("starve_after", o_vac, o_sac, o_st);
        check_int("starve_v_grants_before_s", v_acks, LIM);
        check_int("starve_s_grants", s_acks, 1);
        check_int("starve_flag_cycles", st_cycles, 2);
        $display("starvation: %0d V grants then %0d S grant", v_acks, s_acks);

        // Build the debt back to the limit, then reset asynchronously mid GNT_V.
        for (int k = 0; k < LIM - 1; k++) begin
            drive(1, 1, 0, 0, V_A, S_A);
            model_cycle("pre_rst_idle", o_vac, o_sac, o_st);
            drive(1, 1, 0, 1, V_A, S_A);
            model_cycle("pre_rst_gnt", o_vac, o_sac, o_st);
        end
        drive(1, 1, 0, 0, V_A, S_A);
        model_cycle("pre_rst_idle", o_vac, o_sac, o_st);
        drive(1, 1, 0, 1, V_A, S_A);
        #2;
        model_expect(e_rd, e_addr, e_vac, e_sac, e_st);
        check("mid_gnt_v_before_reset", e_rd, e_addr, e_vac, e_sac, e_st);
        rst = 1'b1;
        #1;
        check("async_reset_mid_grant", 1'b0, '0, 1'b0, 1'b0, 1'b0);
        holder = 0; s_debt = 0;
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, V_A, S_A);
        rst = 1'b0;
        $display("async reset: outputs checked between clock edges");

        for (int n = 0; n < 3000; n++) begin
            ra = AW'($urandom());
            rb = AW'($urandom());
            drive($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 2,
                  $urandom_range(0, 9) < 4, ra, rb);
            model_cycle("random", o_vac, o_sac, o_st);
        end
        $display("random: 3000 cycles applied");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
